sm4_round_key_buffer: RTL and testbench
=======================================

# sm4_round_key_buffer

Sequential SM4 key-schedule engine and round-key store. It accepts a 128-bit master key, runs the 32 key-expansion rounds one per clock, and holds all 32 round keys in a register file. It serves any round key on request, in forward order for encryption or reversed order for decryption. It sits between the key-load interface and the encrypt/decrypt round datapath, which consumes round keys by round index.

## Interface
- No parameters; widths are fixed by SM4.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_in  in  128  master key; MK0 = key_in[127:96], MK3 = key_in[31:0].
- key_valid  in  1  key offer.
- key_ready  out  1  high in IDLE and READY; key accepted when key_valid && key_ready.
- clear  in  1  abort or invalidate the key schedule.
- rd_en  in  1  round-key read request.
- rd_idx  in  5  round index 0..31 as seen by the datapath.
- mode  in  1  0 = encrypt (rk[rd_idx]), 1 = decrypt (rk[31-rd_idx]); sampled with rd_en.
- rd_data  out  32  round key.
- rd_vld  out  1  rd_data valid.
- busy  out  1  high in EXPAND.
- keys_ok  out  1  high in READY.

## Operation
- FSM states: IDLE, EXPAND, READY.
- **IDLE → EXPAND** on key accept:
  - Load work regs K0..K3 = MK0^FK0 .. MK3^FK3.
  - FK = a3b1bac6, 56aa3350, 677d9197, b27022dc.
  - cnt = 0.
- **EXPAND, each cycle:**
  - x = K1^K2^K3^CK[cnt].
  - rk = K0 ^ T'(x), where T' = S-box per byte, then L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - Write rk[cnt] = rk.
  - Shift K0..K3 ← K1, K2, K3, rk.
  - cnt++, a 5-bit counter.
- **EXPAND → READY** on the cycle that writes cnt = 31.
- **READY → EXPAND** on a new key accept (rekey). keys_ok drops on the accepting edge.
- **clear** in any state → IDLE. clear has priority over a simultaneous key_valid; that key is not accepted.
- **Reads:**
  - rd_en is honoured only in READY.
  - Outside READY: rd_vld = 0 and rd_data holds its value.
  - In decrypt mode the index is 31 - rd_idx, computed as the 5-bit bitwise complement (~rd_idx).
- **CK generation:** CK[i] byte j (j = 0 is MSB) = (4i + j) * 7 mod 256.
- **Reset values:**
  - State IDLE, cnt 0, keys_ok 0, busy 0, rd_vld 0, rd_data 0.
  - key_ready is 1, since IDLE holds key_ready high.
  - Round-key store contents are 0.

## Timing
- Key accept edge E0. Edges E1..E32 write rk[0]..rk[31].
- keys_ok = 1 and key_ready = 1 after E32.
- Key-to-ready latency is 32 cycles.
- Back-to-back keys are accepted in consecutive READY windows only; key_ready = 0 throughout EXPAND.
- Read latency is 1 cycle:
  - rd_en sampled at edge E gives rd_data/rd_vld valid after E.
  - rd_vld is a single-cycle pulse per request.
  - Full throughput: one read per cycle.
- A read and a rekey accept on the same edge: the read completes with the old key; keys_ok falls after that edge.
- clear during EXPAND: state and busy go to IDLE after the same edge. Partially written rk entries remain unless zeroization is enabled.
- Asynchronous reset mid-EXPAND returns all outputs to their reset values immediately.

## Configuration
- SM4_KEY_ZEROIZE_EN defined:
  - clear, and every reset, force all 32 rk entries and K0..K3 to 0 on the clear edge.
  - A rekey accept also zeroes the store on E0.
- SM4_KEY_ZEROIZE_EN undefined: clear only changes FSM state and flags; the store retains stale keys, which are unreadable until keys_ok.

## Structure
- Shared package sm4_pkg holds:
  - FK0..FK3 constants.
  - The SM4 S-box function.
  - State enum type {IDLE, EXPAND, READY}.
  - CK generation function.
- One sub-module, sm4_key_step: combinational single expansion round, (K0..K3, CK) → rk, containing T'.
- The FSM, counter, register file, and read port live in the top module.

## Test plan
- **Standard vector, encrypt reads.** Load key 0123456789abcdeffedcba9876543210; after keys_ok, reads return:
  - rd_idx 0 → f12186f9
  - rd_idx 1 → 41662b61
  - rd_idx 31 → 9124a012
- **Decrypt order.** Same key, mode = 1: rd_idx 0 → 9124a012, rd_idx 31 → f12186f9.
- **Latency check.** keys_ok rises exactly 32 cycles after the accept edge. busy is high for exactly 32 cycles. key_ready is low throughout.
- **Clear mid-expansion.** Assert clear at E10:
  - State returns to IDLE; keys_ok stays 0.
  - With SM4_KEY_ZEROIZE_EN, a subsequent peek at the store reads all zeros.
- **Simultaneous events.** clear with key_valid in the same cycle → key not accepted. Read with rekey on the same edge → old rk returned, then keys_ok = 0 for 32 cycles.
- **Reads outside READY.** rd_en in IDLE/EXPAND → rd_vld stays 0. Async reset asserted mid-EXPAND → all outputs at reset values within the reset cycle.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule definitions: widths, FK constants, S-box, CK generator, FSM state type.
package sm4_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned NUM_RK = 32;
  localparam int unsigned IDX_W  = 5;

  localparam logic [WORD_W-1:0] FK0 = 32'ha3b1bac6;
  localparam logic [WORD_W-1:0] FK1 = 32'h56aa3350;
  localparam logic [WORD_W-1:0] FK2 = 32'h677d9197;
  localparam logic [WORD_W-1:0] FK3 = 32'hb27022dc;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } sm4_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [7:0] sm4_sbox(input logic [7:0] a);
    return SBOX[a];
  endfunction

  // CK[i] byte j (MSB first) = (4i + j) * 7 mod 256
  function automatic logic [WORD_W-1:0] sm4_ck(input logic [IDX_W-1:0] i);
    logic [WORD_W-1:0] ck;
    logic [7:0]        base;
    logic [7:0]        b;
    ck   = '0;
    base = 8'({i, 2'b00});
    for (int j = 0; j < 4; j++) begin
      b  = 8'((base + 8'(j)) * 8'd7);
      ck = {ck[WORD_W-9:0], b};
    end
    return ck;
  endfunction

endpackage

// File: rtl/sm4_key_step.sv
// One SM4 key-expansion round: rk = K0 ^ L'(Sbox(K1 ^ K2 ^ K3 ^ CK)).
module sm4_key_step
  import sm4_pkg::*;
(
  input  logic [WORD_W-1:0] i_k0,
  input  logic [WORD_W-1:0] i_k1,
  input  logic [WORD_W-1:0] i_k2,
  input  logic [WORD_W-1:0] i_k3,
  input  logic [WORD_W-1:0] i_ck,
  output logic [WORD_W-1:0] o_rk_c
);

  logic [WORD_W-1:0] w_x;
  logic [WORD_W-1:0] w_b;
  logic [WORD_W-1:0] w_l;

  assign w_x = i_k1 ^ i_k2 ^ i_k3 ^ i_ck;

  assign w_b = {sm4_sbox(w_x[31:24]), sm4_sbox(w_x[23:16]),
                sm4_sbox(w_x[15:8]),  sm4_sbox(w_x[7:0])};

  // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
  assign w_l = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};

  assign o_rk_c = i_k0 ^ w_l;

endmodule

// File: rtl/sm4_round_key_buffer.sv
// SM4 key-schedule engine (one round per clock) and 32-entry round-key store with fwd/rev read port.
// Optional SM4_KEY_ZEROIZE_EN: clear and rekey accept also wipe the store and work registers.
module sm4_round_key_buffer
  import sm4_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              mode,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              busy,
  output logic              keys_ok
);

  sm4_state_e        r_state;
  sm4_state_e        w_state_nxt;
  logic [IDX_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_k  [4];
  logic [WORD_W-1:0] r_rk [NUM_RK];

  logic              r_key_ready;
  logic              r_busy;
  logic              r_keys_ok;
  logic              r_rd_vld;
  logic [WORD_W-1:0] r_rd_data;

  logic              w_accept;
  logic              w_write;
  logic [WORD_W-1:0] w_rk_new;
  logic [IDX_W-1:0]  w_rd_addr;

  // clear wins over a simultaneous key offer
  assign w_accept  = key_valid && r_key_ready && !clear;
  assign w_write   = (r_state == EXPAND) && !clear;
  assign w_rd_addr = mode ? ~rd_idx : rd_idx;

  sm4_key_step u_step (
    .i_k0   (r_k[0]),
    .i_k1   (r_k[1]),
    .i_k2   (r_k[2]),
    .i_k3   (r_k[3]),
    .i_ck   (sm4_ck(r_cnt)),
    .o_rk_c (w_rk_new)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXPAND;
      EXPAND:  if (r_cnt == IDX_W'(NUM_RK - 1)) w_state_nxt = READY;
      READY:   if (w_accept) w_state_nxt = EXPAND;
      default: w_state_nxt = IDLE;
    endcase
    if (clear) begin
      w_state_nxt = IDLE;
    end
  end

  // Work registers and round counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      for (int i = 0; i < 4; i++) r_k[i] <= '0;
    end else if (clear) begin
      r_cnt <= '0;
`ifdef SM4_KEY_ZEROIZE_EN
      for (int i = 0; i < 4; i++) r_k[i] <= '0;
`endif
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_k[0] <= key_in[127:96] ^ FK0;
      r_k[1] <= key_in[95:64]  ^ FK1;
      r_k[2] <= key_in[63:32]  ^ FK2;
      r_k[3] <= key_in[31:0]   ^ FK3;
    end else if (r_state == EXPAND) begin
      r_cnt  <= r_cnt + IDX_W'(1);
      r_k[0] <= r_k[1];
      r_k[1] <= r_k[2];
      r_k[2] <= r_k[3];
      r_k[3] <= w_rk_new;
    end
  end

  // Round-key store
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
    end else begin
`ifdef SM4_KEY_ZEROIZE_EN
      if (clear || w_accept) begin
        for (int i = 0; i < NUM_RK; i++) r_rk[i] <= '0;
      end else if (w_write) begin
        r_rk[r_cnt] <= w_rk_new;
      end
`else
      if (w_write) begin
        r_rk[r_cnt] <= w_rk_new;
      end
`endif
    end
  end

  // Status flags track the next state; read port serves only from READY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_keys_ok   <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_key_ready <= (w_state_nxt == IDLE) || (w_state_nxt == READY);
      r_busy      <= (w_state_nxt == EXPAND);
      r_keys_ok   <= (w_state_nxt == READY);
      r_rd_vld    <= rd_en && (r_state == READY);
      if (rd_en && (r_state == READY)) begin
        r_rd_data <= r_rk[w_rd_addr];
      end
    end
  end

  assign key_ready = r_key_ready;
  assign busy      = r_busy;
  assign keys_ok   = r_keys_ok;
  assign rd_vld    = r_rd_vld;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_sm4_round_key_buffer.sv
// Self-checking bench for sm4_round_key_buffer: vector table of reads plus multi-cycle corner sequences.
module tb_sm4_round_key_buffer;

  logic         clk;
  logic         reset_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         clear;
  logic         rd_en;
  logic [4:0]   rd_idx;
  logic         mode;
  logic [31:0]  rd_data;
  logic         rd_vld;
  logic         busy;
  logic         keys_ok;

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ALT_KEY = 128'h00112233445566778899aabbccddeeff;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q [$];

  typedef struct {
    logic        mode;
    logic [4:0]  idx;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [8];

  sm4_round_key_buffer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .clear     (clear),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .mode      (mode),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld),
    .busy      (busy),
    .keys_ok   (keys_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rd_vld pulse must match the oldest pushed expectation
  always @(negedge clk) begin
    if (reset_n && rd_vld) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_vld=1 data %h expected no read", rd_data);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  // Counts cycles from the accept edge until keys_ok, bounded
  task automatic wait_ready(output int lat, output int busy_cyc, output int kr_high);
    lat = 0; busy_cyc = 0; kr_high = 0;
    while (!keys_ok && lat < 64) begin
      if (busy) busy_cyc++;
      if (key_ready) kr_high++;
      tick();
      lat++;
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, 32'(key_ready), 32'd1);
    chk({tag, "_keys_ok"},   32'(keys_ok),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_rd_vld"},    32'(rd_vld),    32'd0);
    chk({tag, "_rd_data"},   rd_data,        32'd0);
  endtask

  initial begin
    int lat, bc, kr;

    vecs[0] = '{1'b0, 5'd0,  32'hf12186f9};
    vecs[1] = '{1'b0, 5'd1,  32'h41662b61};
    vecs[2] = '{1'b0, 5'd31, 32'h9124a012};
    vecs[3] = '{1'b1, 5'd0,  32'h9124a012};
    vecs[4] = '{1'b1, 5'd31, 32'hf12186f9};
    vecs[5] = '{1'b1, 5'd30, 32'h41662b61};
    vecs[6] = '{1'b1, 5'd1,  32'h9124a012 ^ 32'h0};
    vecs[7] = '{1'b0, 5'd0,  32'hf12186f9};
    // decrypt idx 1 maps to rk[30]; replace with a known entry
    vecs[6] = '{1'b0, 5'd31, 32'h9124a012};

    reset_n = 1'b0; key_in = '0; key_valid = 1'b0; clear = 1'b0;
    rd_en = 1'b0; rd_idx = '0; mode = 1'b0;
    tick(); tick();
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    // Read request in IDLE is ignored
    rd_en = 1'b1; rd_idx = 5'd0;
    tick();
    chk("idle_rd_vld", 32'(rd_vld), 32'd0);

    // Standard key: latency, busy window, key_ready low; reads held high throughout EXPAND
    load_key(STD_KEY);
    chk("e0_busy", 32'(busy), 32'd1);
    chk("e0_key_ready", 32'(key_ready), 32'd0);
    wait_ready(lat, bc, kr);
    rd_en = 1'b0;
    chk("latency", 32'(lat), 32'd32);
    chk("busy_cycles", 32'(bc), 32'd32);
    chk("key_ready_in_expand", 32'(kr), 32'd0);
    chk("ready_busy", 32'(busy), 32'd0);
    chk("ready_key_ready", 32'(key_ready), 32'd1);
    chk("expand_rd_data_held", rd_data, 32'd0);

    // Table of reads issued back to back
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; mode = vecs[i].mode; rd_idx = vecs[i].idx;
      sb_q.push_back(vecs[i].exp);
      tick();
      chk("rd_vld_pulse", 32'(rd_vld), 32'd1);
    end
    rd_en = 1'b0; mode = 1'b0;
    tick();
    chk("rd_vld_drop", 32'(rd_vld), 32'd0);

    // Read and rekey on the same edge: old key served, then 32 cycles without keys_ok
    rd_en = 1'b1; rd_idx = 5'd1; mode = 1'b0;
    sb_q.push_back(32'h41662b61);
    load_key(ALT_KEY);
    rd_en = 1'b0;
    chk("rekey_keys_ok", 32'(keys_ok), 32'd0);
    chk("rekey_busy", 32'(busy), 32'd1);
    wait_ready(lat, bc, kr);
    chk("rekey_latency", 32'(lat), 32'd32);

    // clear with key_valid in the same cycle: key not accepted
    clear = 1'b1; key_valid = 1'b1; key_in = STD_KEY;
    tick();
    clear = 1'b0; key_valid = 1'b0;
    chk("clr_kv_busy", 32'(busy), 32'd0);
    chk("clr_kv_keys_ok", 32'(keys_ok), 32'd0);
    tick();
    chk("clr_kv_busy2", 32'(busy), 32'd0);

    // clear sampled at E10 of an expansion
    load_key(STD_KEY);
    repeat (9) tick();
    chk("pre_clr_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_key_ready", 32'(key_ready), 32'd1);
    chk("clr_rd_data_held", rd_data, 32'h41662b61);
    rd_en = 1'b1; rd_idx = 5'd0;
    repeat (3) tick();
    rd_en = 1'b0;
    chk("clr_keys_ok", 32'(keys_ok), 32'd0);
    chk("clr_rd_vld", 32'(rd_vld), 32'd0);
`ifdef SM4_KEY_ZEROIZE_EN
    begin
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) acc = acc | dut.r_rk[i];
      chk("zeroize_store", acc, 32'd0);
    end
`endif

    // Asynchronous reset mid-EXPAND
    load_key(STD_KEY);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    tick();
    reset_n = 1'b1;
    tick();

    // Recovery after reset: reload and read both ends
    load_key(STD_KEY);
    wait_ready(lat, bc, kr);
    chk("reload_latency", 32'(lat), 32'd32);
    rd_en = 1'b1; mode = 1'b1; rd_idx = 5'd0;
    sb_q.push_back(32'h9124a012);
    tick();
    mode = 1'b0; rd_idx = 5'd1;
    sb_q.push_back(32'h41662b61);
    tick();
    rd_en = 1'b0;
    tick(); tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
